// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the peripheral I/O bus arbiter: bus control codes,
// default bus widths and the arbiter FSM state encoding.
package io_bus_arbiter_pkg;

  localparam logic IO_CTRL_READ  = 1'b0;
  localparam logic IO_CTRL_WRITE = 1'b1;

  localparam int ADDRBUS = 16;
  localparam int DATABUS = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage : io_bus_arbiter_pkg

// File: rtl/io_bus_arbiter_if.sv
// Master-side request/response bundle of the I/O bus arbiter. Per-master
// fields are packed, master i occupying slice i of each vector.
interface io_bus_arbiter_if
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDRBUS,
  parameter int DATA_W  = DATABUS
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ctrl;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, req_addr, req_wdata, req_ctrl,
    input  ack, err, rdata
  );

  modport slave (
    input  req, req_addr, req_wdata, req_ctrl,
    output ack, err, rdata
  );

endinterface : io_bus_arbiter_if

// File: rtl/io_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: searches the request vector starting
// one past the last granted master and returns the first requester found.
module io_bus_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule : io_bus_arbiter_rr_picker

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter for the shared peripheral I/O bus: one transfer per
// three cycles (grant, single-cycle bus phase, response with ack/err/rdata).
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_DEV   = 4,
  parameter int ADDR_W    = ADDRBUS,
  parameter int DATA_W    = DATABUS,
  parameter int DEV_IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  io_bus_arbiter_if.slave     m_if,
  output logic [NUM_DEV-1:0]  bus_en,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_ctrl,
  inout  wire  [DATA_W-1:0]   bus_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mapped_q, mapped_d;
  logic                drive_q, drive_d;
  logic [NUM_DEV-1:0]  bus_en_q, bus_en_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                bus_ctrl_q, bus_ctrl_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_ctrl;
  logic [DEV_IDX_W-1:0] sel_dev;
  logic                 sel_mapped;

  io_bus_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req       (m_if.req),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Fields of the candidate master, captured only when the grant is taken.
  assign sel_addr   = m_if.req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata  = m_if.req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign sel_ctrl   = m_if.req_ctrl[gnt_idx];
  assign sel_dev    = sel_addr[ADDR_W-1 -: DEV_IDX_W];
  assign sel_mapped = int'(sel_dev) < NUM_DEV;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (gnt_valid) state_d = ARB_XFER;
      ARB_XFER: state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Bus enables, data drive, ack, err and rdata are one-cycle events and so
  // default to idle; the captured transfer fields hold until the next grant.
  always_comb begin
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mapped_d   = mapped_q;
    bus_addr_d = bus_addr_q;
    bus_ctrl_d = bus_ctrl_q;
    bus_en_d   = '0;
    drive_d    = 1'b0;
    ack_d      = '0;
    err_d      = 1'b0;
    rdata_d    = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          ptr_d      = gnt_idx;
          idx_d      = gnt_idx;
          wdata_d    = sel_wdata;
          mapped_d   = sel_mapped;
          bus_addr_d = sel_addr;
          bus_ctrl_d = sel_ctrl;
          bus_en_d   = sel_mapped ? (NUM_DEV'(1) << sel_dev) : '0;
          drive_d    = sel_mapped && (sel_ctrl == IO_CTRL_WRITE);
        end
      end
      ARB_XFER: begin
        ack_d = NUM_REQ'(1) << idx_q;
        err_d = !mapped_q;
        if (mapped_q && (bus_ctrl_q == IO_CTRL_READ)) rdata_d = bus_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      idx_q      <= '0;
      wdata_q    <= '0;
      mapped_q   <= 1'b0;
      drive_q    <= 1'b0;
      bus_en_q   <= '0;
      bus_addr_q <= '0;
      bus_ctrl_q <= IO_CTRL_READ;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      mapped_q   <= mapped_d;
      drive_q    <= drive_d;
      bus_en_q   <= bus_en_d;
      bus_addr_q <= bus_addr_d;
      bus_ctrl_q <= bus_ctrl_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus_en     = bus_en_q;
  assign bus_addr   = bus_addr_q;
  assign bus_ctrl   = bus_ctrl_q;
  assign bus_data   = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign m_if.ack   = ack_q;
  assign m_if.err   = err_q;
  assign m_if.rdata = rdata_q;

endmodule : io_bus_arbiter

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with three peripherals on the shared bus
// and a probe that owns bus_data whenever no device is enabled.
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int NUM_DEV = 3;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam logic [15:0] PROBE = 16'h5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  logic [NUM_DEV-1:0] bus_en;
  logic [ADDR_W-1:0]  bus_addr;
  logic               bus_ctrl;
  wire  [DATA_W-1:0]  bus_data;

  io_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEV_IDX_W(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_if     (m_if),
    .bus_en   (bus_en),
    .bus_addr (bus_addr),
    .bus_ctrl (bus_ctrl),
    .bus_data (bus_data)
  );

  // Peripherals: dev0 returns 1234, dev1 is the LED register, dev2 returns BEEF.
  logic [15:0] led_q = 16'h0000;
  logic [15:0] dev_val;
  logic        dev_drive;
  logic        probe_drive;

  always_comb begin
    dev_val = 16'h0000;
    if      (bus_en[0]) dev_val = 16'h1234;
    else if (bus_en[1]) dev_val = led_q;
    else if (bus_en[2]) dev_val = 16'hBEEF;
  end

  assign dev_drive   = (bus_en != '0) && (bus_ctrl == IO_CTRL_READ);
  assign probe_drive = (bus_en == '0);
  assign bus_data    = dev_drive   ? dev_val : {DATA_W{1'bz}};
  assign bus_data    = probe_drive ? PROBE   : {DATA_W{1'bz}};

  always @(posedge clk)
    if (bus_en[1] && bus_ctrl == IO_CTRL_WRITE) led_q <= bus_data;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Any extra driver on the bus corrupts the probe or device value seen here.
  always @(negedge clk) begin
    if (mon_en) begin
      check("bus_en_onehot0", 32'($onehot0(bus_en)), 32'd1);
      if (bus_en == '0) check("bus_released", 32'(bus_data), 32'(PROBE));
      else if (bus_ctrl == IO_CTRL_READ) check("bus_read_value", 32'(bus_data), 32'(dev_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic ctrl);
    m_if.req[m]                = 1'b1;
    m_if.req_addr[m*16 +: 16]  = addr;
    m_if.req_wdata[m*16 +: 16] = wdata;
    m_if.req_ctrl[m]           = ctrl;
  endtask

  initial begin
    m_if.req       = '0;
    m_if.req_addr  = '0;
    m_if.req_wdata = '0;
    m_if.req_ctrl  = '0;

    // Reset state
    tick(); tick();
    check("rst_bus_en", 32'(bus_en), 32'h0);
    check("rst_bus_addr", 32'(bus_addr), 32'h0);
    check("rst_bus_ctrl", 32'(bus_ctrl), 32'(IO_CTRL_READ));
    check("rst_ack", 32'(m_if.ack), 32'h0);
    check("rst_err", 32'(m_if.err), 32'h0);
    check("rst_rdata", 32'(m_if.rdata), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single write: m0 -> dev1 (LED)
    set_req(0, 16'h4000, 16'h00A5, IO_CTRL_WRITE);
    tick();
    check("wr_xfer_en", 32'(bus_en), 32'b010);
    check("wr_xfer_addr", 32'(bus_addr), 32'h4000);
    check("wr_xfer_ctrl", 32'(bus_ctrl), 32'(IO_CTRL_WRITE));
    check("wr_xfer_data", 32'(bus_data), 32'h00A5);
    check("wr_xfer_ack", 32'(m_if.ack), 32'h0);
    tick();
    check("wr_resp_ack", 32'(m_if.ack), 32'b01);
    check("wr_resp_err", 32'(m_if.err), 32'h0);
    check("wr_resp_rdata", 32'(m_if.rdata), 32'h0);
    check("wr_resp_en", 32'(bus_en), 32'h0);
    check("wr_led", 32'(led_q), 32'h00A5);
    m_if.req = '0;
    tick();
    check("wr_idle_ack", 32'(m_if.ack), 32'h0);

    // Single read: m1 <- dev2
    set_req(1, 16'h8000, 16'h1111, IO_CTRL_READ);
    tick();
    check("rd_xfer_en", 32'(bus_en), 32'b100);
    check("rd_xfer_ctrl", 32'(bus_ctrl), 32'(IO_CTRL_READ));
    check("rd_xfer_addr", 32'(bus_addr), 32'h8000);
    tick();
    check("rd_resp_ack", 32'(m_if.ack), 32'b10);
    check("rd_resp_rdata", 32'(m_if.rdata), 32'hBEEF);
    check("rd_resp_err", 32'(m_if.err), 32'h0);
    m_if.req = '0;
    tick();
    check("rd_idle_ack", 32'(m_if.ack), 32'h0);
    check("rd_idle_rdata", 32'(m_if.rdata), 32'h0);

    // Contention: both masters request continuously, grants alternate 0,1,0,1
    set_req(0, 16'h4000, 16'h0F0F, IO_CTRL_WRITE);
    set_req(1, 16'h8000, 16'h1111, IO_CTRL_READ);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_xfer_addr", 32'(bus_addr), (i % 2 == 1) ? 32'h8000 : 32'h4000);
      check("cont_xfer_en", 32'(bus_en), (i % 2 == 1) ? 32'b100 : 32'b010);
      check("cont_xfer_ack", 32'(m_if.ack), 32'h0);
      tick();
      check("cont_ack", 32'(m_if.ack), (i % 2 == 1) ? 32'b10 : 32'b01);
      check("cont_rdata", 32'(m_if.rdata), (i % 2 == 1) ? 32'hBEEF : 32'h0);
      tick();
      check("cont_gap_ack", 32'(m_if.ack), 32'h0);
    end
    m_if.req = '0;
    check("cont_led", 32'(led_q), 32'h0F0F);

    // Unmapped device index 3: read by m0, then write by m1
    set_req(0, 16'hC000, 16'h00A5, IO_CTRL_READ);
    tick();
    check("unm_rd_en", 32'(bus_en), 32'h0);
    check("unm_rd_addr", 32'(bus_addr), 32'hC000);
    tick();
    check("unm_rd_ack", 32'(m_if.ack), 32'b01);
    check("unm_rd_err", 32'(m_if.err), 32'h1);
    check("unm_rd_rdata", 32'(m_if.rdata), 32'h0);
    m_if.req = '0;
    tick();
    check("unm_err_clear", 32'(m_if.err), 32'h0);
    set_req(1, 16'hC000, 16'h3333, IO_CTRL_WRITE);
    tick();
    check("unm_wr_en", 32'(bus_en), 32'h0);
    tick();
    check("unm_wr_ack", 32'(m_if.ack), 32'b10);
    check("unm_wr_err", 32'(m_if.err), 32'h1);
    check("unm_wr_rdata", 32'(m_if.rdata), 32'h0);
    m_if.req = '0;
    tick();

    // Reset during a write XFER aborts it and releases the bus
    set_req(0, 16'h0000, 16'h7777, IO_CTRL_WRITE);
    tick();
    check("abort_xfer_en", 32'(bus_en), 32'b001);
    check("abort_xfer_data", 32'(bus_data), 32'h7777);
    rst_n    = 1'b0;
    m_if.req = '0;
    tick();
    check("abort_en", 32'(bus_en), 32'h0);
    check("abort_ack", 32'(m_if.ack), 32'h0);
    check("abort_ctrl", 32'(bus_ctrl), 32'(IO_CTRL_READ));
    check("abort_addr", 32'(bus_addr), 32'h0);
    check("abort_data", 32'(bus_data), 32'(PROBE));
    rst_n = 1'b1;
    tick();
    check("abort_no_ack", 32'(m_if.ack), 32'h0);

    // After reset master 0 wins first, then master 1
    set_req(0, 16'h8000, 16'h2222, IO_CTRL_READ);
    set_req(1, 16'h0000, 16'h4444, IO_CTRL_READ);
    tick();
    check("post_rst_en0", 32'(bus_en), 32'b100);
    tick();
    check("post_rst_ack0", 32'(m_if.ack), 32'b01);
    check("post_rst_rdata0", 32'(m_if.rdata), 32'hBEEF);
    tick();
    tick();
    check("post_rst_en1", 32'(bus_en), 32'b001);
    tick();
    check("post_rst_ack1", 32'(m_if.ack), 32'b10);
    check("post_rst_rdata1", 32'(m_if.rdata), 32'h1234);
    m_if.req = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_io_bus_arbiter
